// File: rtl/program_ram_loader.sv
// Writable instruction memory with a byte-stream boot loader. Fetches have one
// cycle of latency; while a frame is loading the core is held and sees NOPs.
module program_ram_loader #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 16'hC800
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] code_addr,
    output logic [DATA_WIDTH-1:0] code_data,
    output logic                  cpu_hold,
    input  logic                  load_start,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_abort,
    output logic                  ld_done,
    output logic                  ld_error,
    output logic [15:0]           ld_count
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int IW    = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_SUM, S_ERR, S_FIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             len_reg, len_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0]   waddr_reg, waddr_next;
    logic [DATA_WIDTH-1:0]   sum_reg, sum_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [15:0]             count_reg, count_next;
    logic                    error_reg, error_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   word_asm;
    logic [15:0]             len_new;
    logic                    mem_we;
    logic                    accept;
    logic                    last_byte;

    // Bytes arrive low byte first, so each new byte enters at the top lane
    // and the older lanes shift down; after BPW bytes the first is lowest.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            if (gi == BPW - 1) begin : g_top
                assign word_asm[gi*8 +: 8] = ld_byte;
            end else begin : g_low
                assign word_asm[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    assign ld_ready  = (state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                       (state_reg == S_DATA) || (state_reg == S_SUM);
    assign cpu_hold  = (state_reg != S_IDLE);
    assign ld_done   = (state_reg == S_FIN);
    assign ld_error  = error_reg;
    assign ld_count  = count_reg;
    assign accept    = reset_n && ld_valid && ld_ready && !ld_abort;
    assign last_byte = (idx_reg == IW'(BPW - 1));
    assign len_new   = {ld_byte, len_reg[7:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
            waddr_reg <= '0;
            sum_reg   <= '0;
            shift_reg <= '0;
            count_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            waddr_reg <= waddr_next;
            sum_reg   <= sum_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        waddr_next = waddr_reg;
        sum_next   = sum_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        error_next = error_reg;
        mem_we     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (load_start) begin
                    state_next = S_LEN0;
                    error_next = 1'b0;
                    count_next = '0;
                    idx_next   = '0;
                    waddr_next = '0;
                    sum_next   = '0;
                    shift_next = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_next   = {len_reg[15:8], ld_byte};
                    state_next = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_next = len_new;
                    if (32'(len_new) > DEPTH)
                        state_next = S_ERR;
                    else if (len_new == 16'd0)
                        state_next = S_SUM;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_next = word_asm;
                    if (last_byte) begin
                        idx_next   = '0;
                        mem_we     = 1'b1;
                        waddr_next = waddr_reg + ADDR_WIDTH'(1);
                        sum_next   = sum_reg + word_asm;
                        if (32'(count_reg) < DEPTH)
                            count_next = count_reg + 16'd1;
                        // count never exceeds L here, so the unsaturated
                        // increment is a valid word counter for termination
                        if (count_reg + 16'd1 == len_reg)
                            state_next = S_SUM;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            S_SUM: begin
                if (accept) begin
                    shift_next = word_asm;
                    if (last_byte) begin
                        idx_next   = '0;
                        state_next = (word_asm == sum_reg) ? S_FIN : S_ERR;
                    end else begin
                        idx_next = idx_reg + IW'(1);
                    end
                end
            end
            S_ERR: begin
                error_next = 1'b1;
                state_next = S_FIN;
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (ld_abort && ld_ready)
            state_next = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[waddr_reg] <= word_asm;
    end

    // Writes only happen while the core is held, so the fetch read never
    // collides with a write.
    always_ff @(posedge clk) begin
        if (!reset_n)
            code_data <= NOP_WORD;
        else if (state_reg != S_IDLE)
            code_data <= NOP_WORD;
        else
            code_data <= mem[code_addr];
    end

endmodule

// File: tb/tb_program_ram_loader.sv
// Directed bench for program_ram_loader: frames with hand-computed results,
// error paths, abort, reset mid-load and plain fetch streaming.
module tb_program_ram_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  code_addr;
    logic [15:0] code_data;
    logic        cpu_hold;
    logic        load_start;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_abort;
    logic        ld_done;
    logic        ld_error;
    logic [15:0] ld_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_ram_loader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .NOP_WORD  (16'hC800)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .code_addr (code_addr),
        .code_data (code_data),
        .cpu_hold  (cpu_hold),
        .load_start(load_start),
        .ld_byte   (ld_byte),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_abort  (ld_abort),
        .ld_done   (ld_done),
        .ld_error  (ld_error),
        .ld_count  (ld_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ld_byte  = b;
        ld_valid = 1'b1;
        while (!ld_ready && n < 16) begin
            tick();
            n++;
        end
        if (!ld_ready)
            chk("ld_ready_timeout", {31'd0, ld_ready}, 32'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    // Waits (bounded) for the done pulse, checks status in that cycle, then
    // checks the hold releases on the following cycle.
    task automatic finish_load(input string tag, input logic exp_err, input logic [15:0] exp_cnt);
        int n;
        n = 0;
        while (!ld_done && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, {31'd0, ld_done}, 32'd1);
        chk({tag, "_error"}, {31'd0, ld_error}, {31'd0, exp_err});
        chk({tag, "_count"}, {16'd0, ld_count}, {16'd0, exp_cnt});
        tick();
        chk({tag, "_hold_drop"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
        code_addr = a;
        tick();
        chk(tag, {16'd0, code_data}, {16'd0, exp});
    endtask

    initial begin
        reset_n    = 1'b0;
        code_addr  = 8'd0;
        load_start = 1'b0;
        ld_byte    = 8'd0;
        ld_valid   = 1'b0;
        ld_abort   = 1'b0;
        tick();
        tick();
        chk("rst_code_data", {16'd0, code_data}, 32'h0000C800);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_done", {31'd0, ld_done}, 32'd0);
        chk("rst_error", {31'd0, ld_error}, 32'd0);
        chk("rst_count", {16'd0, ld_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Good frame: words 2601, 0009, checksum 260A
        start_load();
        chk("f1_hold", {31'd0, cpu_hold}, 32'd1);
        chk("f1_ready", {31'd0, ld_ready}, 32'd1);
        send_bytes('{8'h02, 8'h00, 8'h01, 8'h26, 8'h09, 8'h00});
        chk("f1_nop_during_load", {16'd0, code_data}, 32'h0000C800);
        send_bytes('{8'h0A, 8'h26});
        finish_load("f1", 1'b0, 16'd2);
        fetch("f1_mem0", 8'd0, 16'h2601);
        fetch("f1_mem1", 8'd1, 16'h0009);

        // Bad checksum: words still land in RAM
        start_load();
        send_bytes('{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00});
        finish_load("f2", 1'b1, 16'd2);
        fetch("f2_mem0", 8'd0, 16'h1234);
        fetch("f2_mem1", 8'd1, 16'h5678);

        // L = 257 exceeds depth
        start_load();
        send_bytes('{8'h01, 8'h01});
        chk("f3_err_state_ready", {31'd0, ld_ready}, 32'd0);
        chk("f3_err_state_hold", {31'd0, cpu_hold}, 32'd1);
        finish_load("f3", 1'b1, 16'd0);
        fetch("f3_mem0", 8'd0, 16'h1234);

        // Empty frame
        start_load();
        send_bytes('{8'h00, 8'h00, 8'h00, 8'h00});
        finish_load("f4", 1'b0, 16'd0);
        fetch("f4_mem0", 8'd0, 16'h1234);

        // Abort mid-word, with a competing byte on the abort cycle
        start_load();
        send_bytes('{8'h04, 8'h00, 8'hAA, 8'hBB});
        start_load();
        chk("f5_start_ignored_count", {16'd0, ld_count}, 32'd1);
        chk("f5_start_ignored_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'hCC);
        ld_byte  = 8'hDD;
        ld_valid = 1'b1;
        ld_abort = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_abort = 1'b0;
        chk("f5_abort_ready", {31'd0, ld_ready}, 32'd0);
        finish_load("f5", 1'b1, 16'd1);
        fetch("f5_mem0", 8'd0, 16'hBBAA);
        fetch("f5_mem1", 8'd1, 16'h5678);

        // Reset in the middle of a load
        start_load();
        send_bytes('{8'h02, 8'h00, 8'h11});
        reset_n = 1'b0;
        tick();
        chk("f6_rst_code_data", {16'd0, code_data}, 32'h0000C800);
        chk("f6_rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("f6_rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("f6_rst_done", {31'd0, ld_done}, 32'd0);
        chk("f6_rst_error", {31'd0, ld_error}, 32'd0);
        chk("f6_rst_count", {16'd0, ld_count}, 32'd0);
        reset_n = 1'b1;
        fetch("f6_mem0", 8'd0, 16'hBBAA);

        // Three-word load then back-to-back fetches
        start_load();
        send_bytes('{8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h66, 8'h66});
        finish_load("f7", 1'b0, 16'd3);
        fetch("f7_stream0", 8'd0, 16'h1111);
        fetch("f7_stream1", 8'd1, 16'h2222);
        fetch("f7_stream2", 8'd2, 16'h3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
